mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch stage (instruction reads) and the MEM stage (data loads and stores).
- Serializes the requests, latches results into per-requester hold registers, and raises a pipeline-wide stall.
- The stall is ORed into the hazard unit's StallF/StallD path and also freezes E/M/W.
- A requester served early keeps its result and is never re-issued while the other side is still outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch wants the word at i_addr.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  held instruction word.
- d_req  in  1  MEM stage has a load or store.
- d_we  in  1  1 = store.
- d_be  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  held load data.
- mem_stall  out  1  freeze the whole pipeline this cycle.
- mem_en  out  1  one-cycle command strobe.
- mem_we  out  1  command is a write.
- mem_be  out  DATA_W/8  byte enables.
- mem_addr  out  ADDR_W  command address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (rst=0, async), all cleared immediately:
  - state=IDLE, cnt=0, owner=I.
  - i_ok=0, d_ok=0.
  - mem_en/mem_we/mem_be/mem_addr/mem_wdata=0.
  - i_rdata=d_rdata=0.
  - Any in-flight transaction is abandoned; a late mem_rdata is ignored.
- Pending sets are i_pend = i_req & ~i_ok and d_pend = d_req & ~d_ok.
- IDLE:
  - If d_pend, latch the D command and set owner=D.
  - Else if i_pend, latch the I command (we=0, be=all ones) and set owner=I.
  - Data always has priority because it is the older instruction.
  - At the edge: mem_en=1 for exactly one cycle, mem_* hold the latched values, cnt=MEM_LAT, state=WAIT.
- WAIT:
  - mem_en=0; mem_addr/mem_wdata/mem_be/mem_we stay stable.
  - cnt decrements each cycle.
  - In the cycle cnt==0: if owner=I, capture mem_rdata into i_rdata; if owner=D and a read, capture into d_rdata (a write leaves d_rdata unchanged).
  - At that edge set the owner's ok flag and go to IDLE.
- Requester inputs changing or dropping during WAIT are ignored. The transaction completes and its ok flag is still set.
- mem_stall = i_pend | d_pend, combinational from registered ok flags and the req inputs.
- Advance: in any cycle with mem_stall=0, clear i_ok and d_ok at the edge so the next instruction's requests are served fresh.
- No request is re-issued while its ok flag is set.
- One bubble cycle in IDLE between transactions.
- Single access cost is MEM_LAT+2 stall cycles. Both sides cost 2*(MEM_LAT+2).
- The counter is 4 bits wide; MEM_LAT=1 gives one WAIT cycle with cnt==0 after the strobe cycle.

Decomposition:
- Shared package (cpu_pkg):
  - Arbiter state encoding (IDLE=1'b0, WAIT=1'b1).
  - Owner encoding (OWN_I=0, OWN_D=1).
  - Default widths ADDR_W/DATA_W.
- One natural sub-module: mem_lat_counter. It loads on the start pulse, decrements, and flags cnt==0.

Test Plan:
- Reset mid-transaction, MEM_LAT=2: d_req with rst pulled low during WAIT -> mem_en=0 and mem_stall follows d_req. No capture, state IDLE. After rst=1 the request re-issues and completes normally.
- Lone fetch, MEM_LAT=2: i_req=1 at cycle 0 with i_addr=0x0040_0000 and memory word 0x2008_0005 ->
  - mem_en=1 in cycle 1 with mem_addr=0x0040_0000 and mem_we=0.
  - mem_stall=1 in cycles 0-3.
  - i_rdata=0x2008_0005 and mem_stall=0 in cycle 4.
- Simultaneous requests: i_req=d_req=1, d_we=0, d_addr=0x1000_0010 holding 0xDEAD_BEEF ->
  - D is issued first (cycle 1), then I (cycle 5).
  - d_rdata=0xDEAD_BEEF from cycle 4; no second D strobe.
  - mem_stall drops at cycle 8.
- Store: d_we=1, d_be=4'b0011, d_wdata=0x1234_5678, d_addr=0x1000_0020 ->
  - Single mem_en with mem_we=1, mem_be=4'b0011.
  - d_rdata unchanged; mem_stall=0 after MEM_LAT+2 cycles.
- Sticky ok: after D completes with i_req held, let d_req stay 1 through the I transaction -> exactly one mem_en with owner D. Both ok flags clear on the cycle mem_stall=0.
- MEM_LAT=1 build: lone i_req -> mem_stall high for 3 cycles. mem_rdata is sampled in the cycle right after mem_en.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings and default widths for the unified-memory port arbiter.
// The arbiter and its latency counter both import this package.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Fixed-latency down-counter: loads LAT on start, counts down to zero and holds.
// zero tells the arbiter the read data is on mem_rdata this cycle.
module mem_lat_counter
    import cpu_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic zero
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on start, otherwise saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and MEM-stage accesses onto one fixed-latency memory port,
// holding each requester's result until the whole pipeline can advance.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                i_ok_q, i_ok_d;
    logic                d_ok_q, d_ok_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_pend_s, d_pend_s, stall_s;
    logic                start_s, cnt_zero_s;

    mem_lat_counter #(
        .LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .zero  (cnt_zero_s)
    );

    // Arbitration, command latch and result capture.
    always_comb begin
        i_pend_s    = i_req & ~i_ok_q;
        d_pend_s    = d_req & ~d_ok_q;
        stall_s     = i_pend_s | d_pend_s;
        state_d     = state_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        start_s     = 1'b0;
        // The pipeline advances on a stall-free cycle; completion below wins.
        if (!stall_s) begin
            i_ok_d = 1'b0;
            d_ok_d = 1'b0;
        end else begin
            i_ok_d = i_ok_q;
            d_ok_d = d_ok_q;
        end
        case (state_q)
            IDLE: begin
                if (d_pend_s) begin
                    owner_d     = OWN_D;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    start_s     = 1'b1;
                    state_d     = WAIT;
                end else if (i_pend_s) begin
                    owner_d     = OWN_I;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = {BE_W{1'b1}};
                    mem_addr_d  = i_addr;
                    mem_wdata_d = {DATA_W{1'b0}};
                    start_s     = 1'b1;
                    state_d     = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_zero_s) begin
                    state_d = IDLE;
                    if (owner_q == OWN_I) begin
                        i_rdata_d = mem_rdata;
                        i_ok_d    = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                        d_ok_d = 1'b1;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, command and hold registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            i_ok_q      <= 1'b0;
            d_ok_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= {BE_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            i_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            i_ok_q      <= i_ok_d;
            d_ok_q      <= d_ok_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_stall = stall_s;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance and a MEM_LAT=1
// instance, each driven against a memory model that returns data only in the exact latency cycle.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic [3:0]  d_be = 4'h0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall, mem_en, mem_we;
    logic [3:0]  mem_be;

    logic        i_req_1 = 1'b0;
    logic [31:0] i_addr_1 = 32'h0;
    logic [31:0] i_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        mem_stall_1, mem_en_1, mem_we_1;
    logic [3:0]  mem_be_1;

    logic [31:0] mem_a [logic [31:0]];
    logic [31:0] wr_w;
    logic        v1 = 1'b0, v2 = 1'b0, v1b = 1'b0;
    logic [31:0] d1 = 32'h0, d2 = 32'h0, d1b = 32'h0;
    int          en_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata),
        .mem_stall(mem_stall), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req_1), .i_addr(i_addr_1), .i_rdata(i_rdata_1),
        .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0),
        .d_wdata(32'h0), .d_rdata(d_rdata_1),
        .mem_stall(mem_stall_1), .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_be(mem_be_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
    );

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Memory models: read word is presented only MEM_LAT cycles after the strobe.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_w = rd_word(mem_addr);
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) wr_w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_a[mem_addr] = wr_w;
        end
        if (mem_en) en_cnt++;
        v1  <= mem_en && !mem_we;
        d1  <= rd_word(mem_addr);
        v2  <= v1;
        d2  <= d1;
        v1b <= mem_en_1 && !mem_we_1;
        d1b <= rd_word(mem_addr_1);
    end

    assign mem_rdata   = v2  ? d2  : 32'hBAD0_BAD0;
    assign mem_rdata_1 = v1b ? d1b : 32'hBAD0_BAD0;

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_be, mem_stall} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got en=%b we=%b be=%h stall=%b required all 0", mem_en, mem_we, mem_be, mem_stall);
        end
        n_checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
            n_errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h i=%h d=%h required 0", mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        next_cyc();
        d_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b1 || mem_en !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_stall_follows: got stall=%b en=%b required 1 0", mem_stall, mem_en);
        end
        next_cyc();
        d_req = 1'b0;
        rst   = 1'b1;
        next_cyc();
        next_cyc();
    endtask

    task automatic test_lone_fetch();
        i_req  = 1'b1;
        i_addr = 32'h0040_0000;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_stall !== (c <= 3) || mem_en !== (c == 1)) begin
                n_errors++;
                $display("FAIL fetch_cyc%0d: got stall=%b en=%b required %b %b", c, mem_stall, mem_en, c <= 3, c == 1);
            end
            if (c == 1) begin
                n_checks++;
                if (mem_addr !== 32'h0040_0000 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
                    n_errors++;
                    $display("FAIL fetch_cmd: got addr=%h we=%b be=%h required 00400000 0 f", mem_addr, mem_we, mem_be);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (i_rdata !== 32'h2008_0005) begin
                    n_errors++;
                    $display("FAIL fetch_data: got %h required 20080005", i_rdata);
                end
            end
            next_cyc();
        end
        i_req = 1'b0;
        next_cyc();
    endtask

    task automatic test_simultaneous();
        int base;
        base   = en_cnt;
        i_req  = 1'b1;
        i_addr = 32'h0040_0004;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1000_0010;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_stall !== (c <= 7) || mem_en !== (c == 1 || c == 5)) begin
                n_errors++;
                $display("FAIL simul_cyc%0d: got stall=%b en=%b", c, mem_stall, mem_en);
            end
            if (c == 1 || c == 5) begin
                n_checks++;
                if (mem_addr !== ((c == 1) ? 32'h1000_0010 : 32'h0040_0004) || mem_we !== 1'b0) begin
                    n_errors++;
                    $display("FAIL simul_order_cyc%0d: got addr=%h we=%b", c, mem_addr, mem_we);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (d_rdata !== 32'hDEAD_BEEF) begin
                    n_errors++;
                    $display("FAIL simul_ddata: got %h required deadbeef", d_rdata);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (i_rdata !== 32'h8C09_0000 || d_rdata !== 32'hDEAD_BEEF) begin
                    n_errors++;
                    $display("FAIL simul_final: got i=%h d=%h required 8c090000 deadbeef", i_rdata, d_rdata);
                end
            end
            next_cyc();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        n_checks++;
        if (en_cnt - base != 2) begin
            n_errors++;
            $display("FAIL simul_strobes: got %0d required 2", en_cnt - base);
        end
        next_cyc();
    endtask

    task automatic test_store();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_wdata = 32'h1234_5678;
        d_addr  = 32'h1000_0020;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_stall !== (c <= 3) || mem_en !== (c == 1)) begin
                n_errors++;
                $display("FAIL store_cyc%0d: got stall=%b en=%b", c, mem_stall, mem_en);
            end
            if (c == 1 || c == 3) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 32'h1000_0020 || mem_wdata !== 32'h1234_5678) begin
                    n_errors++;
                    $display("FAIL store_cmd_cyc%0d: got we=%b be=%h addr=%h wdata=%h", c, mem_we, mem_be, mem_addr, mem_wdata);
                end
            end
            next_cyc();
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        n_checks++;
        if (d_rdata !== 32'hDEAD_BEEF || rd_word(32'h1000_0020) !== 32'hAAAA_5678) begin
            n_errors++;
            $display("FAIL store_result: got d=%h mem=%h required deadbeef aaaa5678", d_rdata, rd_word(32'h1000_0020));
        end
        next_cyc();
    endtask

    task automatic test_sticky();
        int d_str, i_str;
        d_str  = 0;
        i_str  = 0;
        i_req  = 1'b1;
        i_addr = 32'h0040_0008;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1000_0020;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (mem_en === 1'b1 && mem_addr === 32'h1000_0020) d_str++;
            if (mem_en === 1'b1 && mem_addr === 32'h0040_0008) i_str++;
            if (c == 8) begin
                n_checks++;
                if (mem_stall !== 1'b0 || i_rdata !== 32'h2402_000A || d_rdata !== 32'hAAAA_5678) begin
                    n_errors++;
                    $display("FAIL sticky_done: got stall=%b i=%h d=%h required 0 2402000a aaaa5678", mem_stall, i_rdata, d_rdata);
                end
            end
            next_cyc();
        end
        n_checks++;
        if (d_str != 1 || i_str != 1) begin
            n_errors++;
            $display("FAIL sticky_strobes: got d=%0d i=%0d required 1 1", d_str, i_str);
        end
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL sticky_ok_cleared: got stall=%b required 1", mem_stall);
        end
        next_cyc();
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h1000_0020) begin
            n_errors++;
            $display("FAIL sticky_reissue: got en=%b addr=%h required 1 10000020", mem_en, mem_addr);
        end
        next_cyc();
        i_req = 1'b0;
        d_req = 1'b0;
        for (int c = 0; c < 5; c++) next_cyc();
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b0 || mem_en !== 1'b0 || d_rdata !== 32'hAAAA_5678) begin
            n_errors++;
            $display("FAIL sticky_drop: got stall=%b en=%b d=%h", mem_stall, mem_en, d_rdata);
        end
        next_cyc();
    endtask

    task automatic test_reset_mid();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1000_0010;
        next_cyc();
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b0 || mem_addr !== 32'h0 || d_rdata !== 32'h0 || mem_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_clear: got en=%b addr=%h d=%h stall=%b", mem_en, mem_addr, d_rdata, mem_stall);
        end
        next_cyc();
        @(negedge clk);
        n_checks++;
        if (d_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL rstmid_late_data: got %h required 0", d_rdata);
        end
        next_cyc();
        d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_stall_drop: got %b required 0", mem_stall);
        end
        next_cyc();
        rst   = 1'b1;
        d_req = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_stall !== (c <= 3) || mem_en !== (c == 1)) begin
                n_errors++;
                $display("FAIL rstmid_reissue_cyc%0d: got stall=%b en=%b", c, mem_stall, mem_en);
            end
            if (c == 4) begin
                n_checks++;
                if (d_rdata !== 32'hDEAD_BEEF) begin
                    n_errors++;
                    $display("FAIL rstmid_data: got %h required deadbeef", d_rdata);
                end
            end
            next_cyc();
        end
        d_req = 1'b0;
        next_cyc();
    endtask

    task automatic test_lat1();
        i_req_1  = 1'b1;
        i_addr_1 = 32'h0040_0000;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_stall_1 !== (c <= 2) || mem_en_1 !== (c == 1)) begin
                n_errors++;
                $display("FAIL lat1_cyc%0d: got stall=%b en=%b", c, mem_stall_1, mem_en_1);
            end
            if (c == 1) begin
                n_checks++;
                if (mem_addr_1 !== 32'h0040_0000 || mem_be_1 !== 4'hF || mem_wdata_1 !== 32'h0) begin
                    n_errors++;
                    $display("FAIL lat1_cmd: got addr=%h be=%h wdata=%h", mem_addr_1, mem_be_1, mem_wdata_1);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (i_rdata_1 !== 32'h2008_0005 || d_rdata_1 !== 32'h0) begin
                    n_errors++;
                    $display("FAIL lat1_data: got i=%h d=%h required 20080005 0", i_rdata_1, d_rdata_1);
                end
            end
            next_cyc();
        end
        i_req_1 = 1'b0;
        next_cyc();
    endtask

    initial begin
        mem_a[32'h0040_0000] = 32'h2008_0005;
        mem_a[32'h0040_0004] = 32'h8C09_0000;
        mem_a[32'h0040_0008] = 32'h2402_000A;
        mem_a[32'h1000_0010] = 32'hDEAD_BEEF;
        mem_a[32'h1000_0020] = 32'hAAAA_AAAA;
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_store();
        test_sticky();
        test_reset_mid();
        test_lat1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
